// File: rtl/phy_link_monitor.sv
// Periodically reads a PHY status register and publishes link, speed and duplex.
// Define PHY_AN_RESTART_EN to enable autonegotiation-restart writes to register 0.
module phy_link_monitor #(
    parameter int unsigned POLL_CYCLES    = 1000000,
    parameter logic [4:0]  SPEC_REG       = 5'd17,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [4:0]  o_phy_addr,
    output logic [31:0] o_phy_wr_data,
    output logic        o_phy_rdwn,
    output logic        o_phy_request,
    input  logic        i_phy_done,
    input  logic [31:0] i_phy_rd_data,
    input  logic        i_an_restart,
    output logic        o_link_up,
    output logic [1:0]  o_speed,
    output logic        o_full_duplex,
    output logic        o_status_chg,
    output logic        o_timeout_err
);

    localparam int POLL_W = $clog2(POLL_CYCLES);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] DECODE  = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_WAIT = 3'd5;

    logic [2:0]        state_reg;
    logic [POLL_W-1:0] poll_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [15:0]       rd_data_reg;
    logic [4:0]        addr_reg;
    logic [31:0]       wr_data_reg;
    logic              rdwn_reg;
    logic              request_reg;
    logic              link_up_reg;
    logic [1:0]        speed_reg;
    logic              duplex_reg;
    logic              status_chg_reg;
    logic              timeout_err_reg;

    logic              link_next;
    logic [1:0]        speed_next;
    logic              duplex_next;

`ifdef PHY_AN_RESTART_EN
    localparam logic [31:0] AN_RESTART_DATA = 32'h0000_1340;
    logic an_pending_reg;
    logic unused_inputs;
    assign unused_inputs = ^i_phy_rd_data[31:16];
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_phy_rd_data[31:16], i_an_restart};
`endif

    // Speed code 11 is reserved and reported as link down; speed/duplex keep their last good values.
    always_comb begin
        link_next   = rd_data_reg[10] && (rd_data_reg[15:14] != 2'b11);
        speed_next  = link_next ? rd_data_reg[15:14] : speed_reg;
        duplex_next = link_next ? rd_data_reg[13] : duplex_reg;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            poll_cnt_reg    <= '0;
            wait_cnt_reg    <= '0;
            rd_data_reg     <= '0;
            addr_reg        <= '0;
            wr_data_reg     <= '0;
            rdwn_reg        <= 1'b0;
            request_reg     <= 1'b0;
            link_up_reg     <= 1'b0;
            speed_reg       <= 2'b00;
            duplex_reg      <= 1'b0;
            status_chg_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef PHY_AN_RESTART_EN
            an_pending_reg  <= 1'b0;
`endif
        end else begin
            request_reg     <= 1'b0;
            status_chg_reg  <= 1'b0;
            timeout_err_reg <= 1'b0;
`ifdef PHY_AN_RESTART_EN
            if (i_an_restart) begin
                an_pending_reg <= 1'b1;
            end
`endif
            case (state_reg)
                IDLE: begin
`ifdef PHY_AN_RESTART_EN
                    if (an_pending_reg) begin
                        state_reg      <= WR_REQ;
                        request_reg    <= 1'b1;
                        rdwn_reg       <= 1'b0;
                        addr_reg       <= 5'd0;
                        wr_data_reg    <= AN_RESTART_DATA;
                        wait_cnt_reg   <= '0;
                        poll_cnt_reg   <= '0;
                        an_pending_reg <= i_an_restart;
                    end else
`endif
                    if (poll_cnt_reg == POLL_LAST) begin
                        state_reg    <= RD_REQ;
                        request_reg  <= 1'b1;
                        rdwn_reg     <= 1'b1;
                        addr_reg     <= SPEC_REG;
                        wr_data_reg  <= '0;
                        wait_cnt_reg <= '0;
                        poll_cnt_reg <= '0;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + POLL_W'(1);
                    end
                end
                // The wait counter starts at the request cycle, so a timeout fires TIMEOUT_CYCLES after it.
                RD_REQ: begin
                    state_reg    <= RD_WAIT;
                    wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                end
                RD_WAIT: begin
                    if (i_phy_done) begin
                        rd_data_reg <= i_phy_rd_data[15:0];
                        state_reg   <= DECODE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        timeout_err_reg <= 1'b1;
                        link_up_reg     <= 1'b0;
                        status_chg_reg  <= link_up_reg;
                        poll_cnt_reg    <= '0;
                        state_reg       <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    link_up_reg    <= link_next;
                    speed_reg      <= speed_next;
                    duplex_reg     <= duplex_next;
                    status_chg_reg <= (link_next != link_up_reg) || (speed_next != speed_reg)
                                      || (duplex_next != duplex_reg);
                    poll_cnt_reg   <= '0;
                    state_reg      <= IDLE;
                end
`ifdef PHY_AN_RESTART_EN
                WR_REQ: begin
                    state_reg    <= WR_WAIT;
                    wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                end
                WR_WAIT: begin
                    if (i_phy_done) begin
                        poll_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        timeout_err_reg <= 1'b1;
                        poll_cnt_reg    <= '0;
                        state_reg       <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
`else
                WR_REQ:  state_reg <= IDLE;
                WR_WAIT: state_reg <= IDLE;
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_phy_addr    = addr_reg;
    assign o_phy_wr_data = wr_data_reg;
    assign o_phy_rdwn    = rdwn_reg;
    assign o_phy_request = request_reg;
    assign o_link_up     = link_up_reg;
    assign o_speed       = speed_reg;
    assign o_full_duplex = duplex_reg;
    assign o_status_chg  = status_chg_reg;
    assign o_timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_phy_link_monitor.sv
// Randomized bench for phy_link_monitor with a behavioural PHY responder and status model.
module tb_phy_link_monitor;

    localparam int         POLL = 16;
    localparam int         TMO  = 8;
    localparam logic [4:0] SREG = 5'd17;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [4:0]  o_phy_addr;
    logic [31:0] o_phy_wr_data;
    logic        o_phy_rdwn;
    logic        o_phy_request;
    logic        i_phy_done;
    logic [31:0] i_phy_rd_data;
    logic        i_an_restart;
    logic        o_link_up;
    logic [1:0]  o_speed;
    logic        o_full_duplex;
    logic        o_status_chg;
    logic        o_timeout_err;

    int checks = 0;
    int errors = 0;

    logic       exp_link;
    logic [1:0] exp_speed;
    logic       exp_dup;
    logic       exp_chg;

    phy_link_monitor #(
        .POLL_CYCLES(POLL),
        .SPEC_REG(SREG),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_rst(i_rst),
        .o_phy_addr(o_phy_addr),
        .o_phy_wr_data(o_phy_wr_data),
        .o_phy_rdwn(o_phy_rdwn),
        .o_phy_request(o_phy_request),
        .i_phy_done(i_phy_done),
        .i_phy_rd_data(i_phy_rd_data),
        .i_an_restart(i_an_restart),
        .o_link_up(o_link_up),
        .o_speed(o_speed),
        .o_full_duplex(o_full_duplex),
        .o_status_chg(o_status_chg),
        .o_timeout_err(o_timeout_err)
    );

    always #5 clk = ~clk;

    // Status rules: link needs bit10 set and a non-reserved speed; speed/duplex hold while down.
    function automatic void model_decode(input logic [15:0] d);
        int         spd;
        logic       lk;
        logic       pl;
        logic [1:0] ps;
        logic       pd;
        pl  = exp_link;
        ps  = exp_speed;
        pd  = exp_dup;
        spd = int'(d) / 16384;
        lk  = d[10] && (spd != 3);
        if (lk) begin
            exp_link  = 1'b1;
            exp_speed = 2'(spd);
            exp_dup   = d[13];
        end else begin
            exp_link  = 1'b0;
        end
        exp_chg = (exp_link != pl) || (exp_speed != ps) || (exp_dup != pd);
    endfunction

    // Starts in an idle cycle; returns in the cycle the read request is visible.
    task automatic expect_poll(input int gap, input bit strays);
        int k;
        int spur;
        k = 0;
        spur = 0;
        while (o_phy_request !== 1'b1 && k < gap + 8) begin
            if (k > 0 && (o_status_chg !== 1'b0 || o_timeout_err !== 1'b0)) spur++;
            i_phy_done    = strays && ($urandom_range(0, 3) == 0);
            i_phy_rd_data = $urandom;
            @(negedge clk);
            k++;
        end
        i_phy_done = 1'b0;
        checks++;
        if (k != gap) begin
            errors++;
            $display("FAIL poll_gap: got %0d cycles, expected %0d", k, gap);
        end
        checks++;
        if (spur != 0) begin
            errors++;
            $display("FAIL idle_pulses: got %0d stray status/timeout pulses, expected 0", spur);
        end
        checks++;
        if ({o_phy_rdwn, o_phy_addr, o_phy_wr_data} !== {1'b1, SREG, 32'd0}) begin
            errors++;
            $display("FAIL read_request: got rdwn=%b addr=%0d data=%h, expected rdwn=1 addr=%0d data=0",
                     o_phy_rdwn, o_phy_addr, o_phy_wr_data, SREG);
        end
    endtask

    // Starts in the read request cycle; returns in the idle cycle after DECODE.
    task automatic do_read(input logic [15:0] data, input int lat, input bit an_pulse);
        int unstable;
        int extra_req;
        unstable = 0;
        extra_req = 0;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (o_phy_request !== 1'b0) extra_req++;
            if ({o_phy_rdwn, o_phy_addr, o_phy_wr_data} !== {1'b1, SREG, 32'd0}) unstable++;
            i_an_restart  = an_pulse && (j == 1 || j == lat);
            i_phy_done    = (j == lat);
            i_phy_rd_data = {16'($urandom), data};
        end
        @(negedge clk);
        i_an_restart  = 1'b0;
        i_phy_done    = 1'($urandom_range(0, 1));
        i_phy_rd_data = $urandom;
        model_decode(data);
        @(negedge clk);
        i_phy_done = 1'b0;
        $display("read data=%h lat=%0d -> link=%b speed=%b duplex=%b chg=%b",
                 data, lat, o_link_up, o_speed, o_full_duplex, o_status_chg);
        checks++;
        if ({o_link_up, o_speed, o_full_duplex} !== {exp_link, exp_speed, exp_dup}) begin
            errors++;
            $display("FAIL read_status: got link=%b speed=%b duplex=%b, expected link=%b speed=%b duplex=%b",
                     o_link_up, o_speed, o_full_duplex, exp_link, exp_speed, exp_dup);
        end
        checks++;
        if (o_status_chg !== exp_chg) begin
            errors++;
            $display("FAIL status_chg: got %b, expected %b", o_status_chg, exp_chg);
        end
        checks++;
        if (unstable != 0 || extra_req != 0 || o_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL read_bus: got unstable=%0d extra_req=%0d timeout=%b, expected 0 0 0",
                     unstable, extra_req, o_timeout_err);
        end
    endtask

    // Starts in the read request cycle with no responder; returns in the idle cycle of the timeout pulse.
    task automatic do_timeout();
        int   j;
        logic old_link;
        old_link = exp_link;
        j = 0;
        while (o_timeout_err !== 1'b1 && j < TMO + 6) begin
            i_phy_done = 1'b0;
            @(negedge clk);
            j++;
        end
        exp_link = 1'b0;
        $display("timeout seen after %0d cycles, link=%b chg=%b", j, o_link_up, o_status_chg);
        checks++;
        if (j != TMO) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles, expected %0d", j, TMO);
        end
        checks++;
        if ({o_link_up, o_speed, o_full_duplex} !== {1'b0, exp_speed, exp_dup}) begin
            errors++;
            $display("FAIL timeout_status: got link=%b speed=%b duplex=%b, expected link=0 speed=%b duplex=%b",
                     o_link_up, o_speed, o_full_duplex, exp_speed, exp_dup);
        end
        checks++;
        if (o_status_chg !== old_link) begin
            errors++;
            $display("FAIL timeout_chg: got %b, expected %b", o_status_chg, old_link);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (4) begin
            i_phy_done    = 1'($urandom_range(0, 1));
            i_an_restart  = 1'($urandom_range(0, 1));
            i_phy_rd_data = $urandom;
            @(negedge clk);
        end
        i_phy_done   = 1'b0;
        i_an_restart = 1'b0;
        i_rst        = 1'b0;
        exp_link = 1'b0; exp_speed = 2'b00; exp_dup = 1'b0; exp_chg = 1'b0;
        checks++;
        if ({o_phy_addr, o_phy_wr_data, o_phy_rdwn, o_phy_request, o_link_up, o_speed,
             o_full_duplex, o_status_chg, o_timeout_err} !== 45'd0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%0d wdata=%h rdwn=%b req=%b link=%b speed=%b dup=%b chg=%b tmo=%b, expected all 0",
                     o_phy_addr, o_phy_wr_data, o_phy_rdwn, o_phy_request, o_link_up, o_speed,
                     o_full_duplex, o_status_chg, o_timeout_err);
        end
    endtask

    task automatic test_first_poll();
        expect_poll(POLL, 1'b0);
        do_read(16'hA400, 5, 1'b0);
    endtask

    task automatic test_same_data();
        expect_poll(POLL, 1'b1);
        do_read(16'hA400, 5, 1'b0);
    endtask

    task automatic test_link_down();
        expect_poll(POLL, 1'b1);
        do_read(16'h0000, 5, 1'b0);
    endtask

    task automatic test_random_reads();
        logic [15:0] data;
        logic [15:0] last;
        last = 16'hA400;
        for (int n = 0; n < 20; n++) begin
            data = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin data[10] = 1'b1; data[15:14] = 2'b11; end
                1: data[10] = 1'b0;
                2: data = last;
                default: data[10] = 1'b1;
            endcase
            last = data;
            expect_poll(POLL, 1'b1);
            do_read(data, $urandom_range(1, TMO - 1), 1'b0);
        end
    endtask

    task automatic test_timeout();
        expect_poll(POLL, 1'b1);
        do_read(16'h6000 | 16'h0400, 2, 1'b0);
        expect_poll(POLL, 1'b1);
        do_timeout();
        expect_poll(POLL, 1'b1);
        do_timeout();
        expect_poll(POLL, 1'b1);
        do_read(16'h8400, 7, 1'b0);
    endtask

`ifdef PHY_AN_RESTART_EN
    task automatic test_an_restart();
        int k;
        int unstable;
        expect_poll(POLL, 1'b1);
        do_read(16'h6400, 5, 1'b1);
        k = 0;
        while (o_phy_request !== 1'b1 && k < 4) begin
            @(negedge clk);
            k++;
        end
        $display("write request addr=%0d data=%h rdwn=%b after %0d idle cycles",
                 o_phy_addr, o_phy_wr_data, o_phy_rdwn, k);
        checks++;
        if ({o_phy_request, o_phy_rdwn, o_phy_addr, o_phy_wr_data} !== {1'b1, 1'b0, 5'd0, 32'h0000_1340}) begin
            errors++;
            $display("FAIL an_write: got req=%b rdwn=%b addr=%0d data=%h, expected req=1 rdwn=0 addr=0 data=00001340",
                     o_phy_request, o_phy_rdwn, o_phy_addr, o_phy_wr_data);
        end
        unstable = 0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            if ({o_phy_request, o_phy_rdwn, o_phy_addr, o_phy_wr_data} !== {1'b0, 1'b0, 5'd0, 32'h0000_1340})
                unstable++;
            i_phy_done = (j == 3);
        end
        @(negedge clk);
        i_phy_done = 1'b0;
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL an_write_bus: got %0d unstable cycles, expected 0", unstable);
        end
        expect_poll(POLL, 1'b1);
        do_read(16'h6400, 3, 1'b0);
    endtask
`else
    task automatic test_an_ignored();
        expect_poll(POLL, 1'b1);
        do_read(16'h6400, 5, 1'b1);
        i_an_restart = 1'b1;
        expect_poll(POLL, 1'b1);
        i_an_restart = 1'b0;
        do_read(16'h6400, 3, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_access();
        expect_poll(POLL, 1'b1);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        exp_link = 1'b0; exp_speed = 2'b00; exp_dup = 1'b0;
        checks++;
        if ({o_phy_request, o_link_up, o_speed, o_full_duplex, o_status_chg, o_timeout_err} !== 7'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got req=%b link=%b speed=%b dup=%b chg=%b tmo=%b, expected all 0",
                     o_phy_request, o_link_up, o_speed, o_full_duplex, o_status_chg, o_timeout_err);
        end
        i_phy_done    = 1'b1;
        i_phy_rd_data = 32'h0000_A400;
        @(negedge clk);
        i_phy_done = 1'b0;
        expect_poll(POLL - 1, 1'b0);
        checks++;
        if ({o_link_up, o_speed, o_full_duplex} !== 4'd0) begin
            errors++;
            $display("FAIL midreset_status: got link=%b speed=%b dup=%b, expected all 0",
                     o_link_up, o_speed, o_full_duplex);
        end
        do_read(16'hA400, 4, 1'b0);
    endtask

    initial begin
        i_rst         = 1'b1;
        i_phy_done    = 1'b0;
        i_phy_rd_data = '0;
        i_an_restart  = 1'b0;
        @(negedge clk);
        test_reset();
        test_first_poll();
        test_same_data();
        test_link_down();
        test_random_reads();
        test_timeout();
`ifdef PHY_AN_RESTART_EN
        test_an_restart();
`else
        test_an_ignored();
`endif
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

endmodule
